// File: rtl/inst_encoder_loader.sv
// Packs decoded RV32I field sets (R, I-ALU, load, S, B) into instruction words,
// queues them in a small FIFO and streams them into imem through a stall-capable write port.
module inst_encoder_loader #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd_addr,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [2:0]        fun3,
  input  logic [6:0]        fun7,
  input  logic [11:0]       imm_value,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0]        OP_R = 7'b0110011;
  localparam logic [6:0]        OP_I = 7'b0010011;
  localparam logic [6:0]        OP_L = 7'b0000011;
  localparam logic [6:0]        OP_S = 7'b0100011;
  localparam logic [6:0]        OP_B = 7'b1100011;
  localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_MAX  = {(ADDR_W+1){1'b1}};
  localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]    OCC_ZERO = {(PTR_W+1){1'b0}};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [31:0]         fifo_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      occ_q, occ_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [31:0]         enc_word_s;
  logic                enc_ok_s;
  logic                xfer_s, push_s, pop_s;

  // Field-set to instruction-word packing; unknown opcodes are flagged unsupported
  always_comb begin
    enc_word_s = 32'd0;
    enc_ok_s   = 1'b0;
    case (opcode)
      OP_R: begin
        enc_word_s = {fun7, rs2_addr, rs1_addr, fun3, rd_addr, opcode};
        enc_ok_s   = 1'b1;
      end
      OP_I, OP_L: begin
        enc_word_s = {imm_value, rs1_addr, fun3, rd_addr, opcode};
        enc_ok_s   = 1'b1;
      end
      OP_S: begin
        enc_word_s = {imm_value[11:5], rs2_addr, rs1_addr, fun3, imm_value[4:0], opcode};
        enc_ok_s   = 1'b1;
      end
      OP_B: begin
        enc_word_s = {imm_value[11], imm_value[9:4], rs2_addr, rs1_addr, fun3,
                      imm_value[3:0], imm_value[10], opcode};
        enc_ok_s   = 1'b1;
      end
      default: begin
        enc_word_s = 32'd0;
        enc_ok_s   = 1'b0;
      end
    endcase
  end

  // in_ready looks only at the registered occupancy, so a full FIFO refuses input even on an ack edge
  assign in_ready = (occ_q != OCC_FULL) && !clr && rst_n;
  assign xfer_s   = in_valid && in_ready;
  assign push_s   = xfer_s && enc_ok_s;
  assign pop_s    = (state_q == S_WRITE) && mem_ack && !clr;

  // Next-state for FSM, FIFO pointers, write address, word counter and error pulse
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = 1'b0;
    if (clr) begin
      state_d  = S_IDLE;
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      occ_d    = OCC_ZERO;
      addr_d   = BASE;
      count_d  = {(ADDR_W+1){1'b0}};
    end else begin
      err_d = xfer_s && !enc_ok_s;
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        addr_d   = addr_q + ADDR_ONE;
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_ONE;
        end else begin
          count_d = count_q;
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
      case (state_q)
        S_IDLE: begin
          if (occ_q != OCC_ZERO) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WRITE: begin
          if (pop_s && (occ_q <= OCC_ONE) && !push_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WRITE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= OCC_ZERO;
      addr_q   <= BASE;
      count_q  <= {(ADDR_W+1){1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 32'd0;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= enc_word_s;
    end
  end

  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = fifo_q[rd_ptr_q];
  assign err       = err_q;
  assign count     = count_q;
  assign busy      = (state_q == S_WRITE) || (occ_q != OCC_ZERO);

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomized and directed bench for inst_encoder_loader; a queue-based model predicts every output each cycle.
module tb_inst_encoder_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, mem_ack;
  logic [6:0]  opcode, fun7;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [2:0]  fun3;
  logic [11:0] imm_value;

  logic        in_ready, mem_we, err, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] count;

  logic        in_ready2, mem_we2, err2, busy2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] q_m [$];
  bit          wr_m, err_m, last_xfer;
  int          writes_m;

  always #5 clk = ~clk;

  inst_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(10), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .fun3(fun3), .fun7(fun7), .imm_value(imm_value), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .err(err), .count(count), .busy(busy)
  );

  inst_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(32'd0)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .fun3(fun3), .fun7(fun7), .imm_value(imm_value), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_ack(mem_ack), .err(err2), .count(count2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic bit sup(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
           (op == 7'b0100011) || (op == 7'b1100011);
  endfunction

  // Reference packing built from shifts and masks of the field values
  function automatic logic [31:0] enc_m(input logic [6:0] op, input logic [4:0] rd, r1, r2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [11:0] im);
    logic [31:0] base, imm;
    base = (32'(r1) << 15) | (32'(f3) << 12) | 32'(op);
    imm  = 32'(im);
    case (op)
      7'b0110011: return base | (32'(f7) << 25) | (32'(r2) << 20) | (32'(rd) << 7);
      7'b0010011, 7'b0000011: return base | (imm << 20) | (32'(rd) << 7);
      7'b0100011: return base | ((imm >> 5) << 25) | (32'(r2) << 20) | ((imm & 32'h1F) << 7);
      7'b1100011: return base | ((imm >> 11) << 31) | (((imm >> 4) & 32'h3F) << 25) |
                         (32'(r2) << 20) | ((imm & 32'hF) << 8) | (((imm >> 10) & 32'h1) << 7);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [6:0] pick_op(input int i);
    case (i)
      0: return 7'b0110011;
      1: return 7'b0010011;
      2: return 7'b0000011;
      3: return 7'b0100011;
      4: return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  task automatic model_reset();
    q_m.delete();
    wr_m = 1'b0;
    err_m = 1'b0;
    writes_m = 0;
  endtask

  task automatic check_outputs();
    bit rdy_m;
    rdy_m = rst_n && !clr && (q_m.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(rdy_m));
    chk("mem_we", 32'(mem_we), 32'(wr_m));
    chk("busy", 32'(busy), 32'(wr_m || q_m.size() != 0));
    chk("err", 32'(err), 32'(err_m));
    chk("count", 32'(count), 32'(writes_m > 2047 ? 2047 : writes_m));
    chk("mem_addr", 32'(mem_addr), 32'(writes_m % 1024));
    chk("mem_we_aw2", 32'(mem_we2), 32'(wr_m));
    chk("mem_addr_aw2", 32'(mem_addr2), 32'(writes_m % 4));
    chk("count_aw2", 32'(count2), 32'(writes_m > 7 ? 7 : writes_m));
    if (wr_m) begin
      chk("mem_wdata", mem_wdata, q_m[0]);
      chk("mem_wdata_aw2", mem_wdata2, q_m[0]);
    end
  endtask

  // One clock: check current outputs, advance the model across the coming edge
  task automatic step();
    int  old_sz;
    bit  xfer;
    #1;
    check_outputs();
    last_xfer = 1'b0;
    if (!rst_n || clr) begin
      model_reset();
    end else begin
      old_sz = q_m.size();
      xfer = in_valid && (old_sz < DEPTH);
      err_m = xfer && !sup(opcode);
      if (wr_m && mem_ack) begin
        void'(q_m.pop_front());
        writes_m++;
      end
      if (xfer && sup(opcode))
        q_m.push_back(enc_m(opcode, rd_addr, rs1_addr, rs2_addr, fun3, fun7, imm_value));
      wr_m = wr_m ? (q_m.size() > 0) : (old_sz > 0);
      last_xfer = xfer;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, r1, r2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] im);
    opcode = op; rd_addr = rd; rs1_addr = r1; rs2_addr = r2;
    fun3 = f3; fun7 = f7; imm_value = im;
  endtask

  task automatic rand_fields(input bit allow_bad);
    set_fields(pick_op($urandom_range(0, allow_bad ? 5 : 4)), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), 7'($urandom), 12'($urandom));
  endtask

  task automatic push(input logic [6:0] op, input logic [4:0] rd, r1, r2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] im);
    int n;
    n = 0;
    set_fields(op, rd, r1, r2, f3, f7, im);
    in_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!last_xfer && n < 20);
    chk("push_accept", 32'(last_xfer), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    mem_ack = 1'b1;
    while ((wr_m || q_m.size() != 0) && n < 30) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [11:0] im;
    int sent, cyc, pushed;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    step();

    // add x3,x1,x2
    mem_ack = 1'b1;
    push(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0);
    step();
    chk("add_we", 32'(mem_we), 32'd1);
    chk("add_addr", 32'(mem_addr), 32'd0);
    chk("add_word", mem_wdata, 32'h002081B3);
    step();
    chk("add_count", 32'(count), 32'd1);
    chk("add_busy", 32'(busy), 32'd0);

    // addi x5,x0,-1 then sw x2,8(x1) back-to-back
    do_clr();
    push(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF);
    push(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 12'd8);
    chk("addi_word", mem_wdata, 32'hFFF00293);
    chk("addi_addr", 32'(mem_addr), 32'd0);
    step();
    chk("sw_word", mem_wdata, 32'h0020A423);
    chk("sw_addr", 32'(mem_addr), 32'd1);
    drain();

    // B round trip through decoder-style unpacking
    push(7'b1100011, 5'd0, 5'd4, 5'd7, 3'b001, 7'd0, 12'hABC);
    step();
    w = mem_wdata;
    im = {w[31], w[7], w[30:25], w[11:8]};
    chk("b_rs1", 32'(w[19:15]), 32'd4);
    chk("b_rs2", 32'(w[24:20]), 32'd7);
    chk("b_fun3", 32'(w[14:12]), 32'd1);
    chk("b_imm", 32'(im), 32'hABC);
    drain();

    // Unsupported opcode between two valid pushes
    do_clr();
    push(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd0);
    push(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0);
    chk("bad_err_hi", 32'(err), 32'd1);
    push(7'b0010011, 5'd6, 5'd1, 5'd0, 3'd0, 7'd0, 12'd5);
    chk("bad_err_lo", 32'(err), 32'd0);
    drain();
    chk("bad_count", 32'(count), 32'd2);
    chk("bad_next_addr", 32'(mem_addr), 32'd2);

    // Stall: ack low 6 cycles while 5 words arrive
    do_clr();
    pushed = 0;
    rand_fields(1'b0);
    for (int c = 0; c < 20; c++) begin
      mem_ack = (c >= 6);
      in_valid = (pushed < 5);
      if (c == 4) chk("stall_ready_low", 32'(in_ready), 32'd0);
      step();
      if (last_xfer) begin
        pushed++;
        rand_fields(1'b0);
      end
    end
    drain();
    chk("stall_pushed", 32'(pushed), 32'd5);
    chk("stall_count", 32'(count), 32'd5);
    chk("aw2_wrap_addr", 32'(mem_addr2), 32'd1);
    chk("aw2_count", 32'(count2), 32'd5);

    // Randomized traffic against the model
    do_clr();
    sent = 0;
    cyc = 0;
    while (sent < 200 && cyc < 3000) begin
      rand_fields($urandom_range(0, 5) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      mem_ack = ($urandom_range(0, 2) != 0);
      step();
      if (last_xfer) sent++;
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd200);
    drain();

    // clr during a stall, with a competing ack and in_valid
    do_clr();
    mem_ack = 1'b0;
    push(7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 12'd0);
    push(7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 12'd3);
    step();
    clr = 1'b1; in_valid = 1'b1; mem_ack = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_we", 32'(mem_we), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    push(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0);
    step();
    chk("clr_next_addr", 32'(mem_addr), 32'd0);
    chk("clr_next_we", 32'(mem_we), 32'd1);
    drain();

    // Asynchronous reset during a write
    mem_ack = 1'b0;
    push(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0);
    step();
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_we", 32'(mem_we), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_ready", 32'(in_ready), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_addr", 32'(mem_addr), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
